// File: rtl/divider_arbiter_pkg.sv
// Shared types for the divider arbiter: FSM state encoding and its width.
package divider_arbiter_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    ARM    = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector: first set request at or after ptr_i,
// wrapping modulo M, returned both one-hot and as an index.
module rr_priority_select #(
  parameter int M    = 4,
  parameter int ID_W = $clog2(M)
) (
  input  logic [M-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [M-1:0]    grant_o,
  output logic [ID_W-1:0] idx_o,
  output logic            valid_o
);

  int              k;
  logic [ID_W-1:0] kk;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    k       = 0;
    kk      = '0;
    for (int i = 0; i < M; i++) begin
      k  = (int'(ptr_i) + i) % M;
      kk = ID_W'(k);
      if (!valid_o && req_i[kk]) begin
        valid_o     = 1'b1;
        grant_o[kk] = 1'b1;
        idx_o       = kk;
      end
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin scheduler that shares one Divider among M requesters: grant,
// latch operands, pulse start, wait for finished, return results with a done pulse.
module divider_arbiter
  import divider_arbiter_pkg::*;
#(
  parameter int N    = 4,
  parameter int M    = 4,
  parameter int ID_W = $clog2(M)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [M-1:0]       i_request,
  input  logic [M*N-1:0]     i_dividend,
  input  logic [M*N-1:0]     i_divisor,
  output logic [M-1:0]       o_grant,
  output logic [M-1:0]       o_done,
  output logic [ID_W-1:0]    o_done_id,
  output logic [N-1:0]       o_quotient,
  output logic [N-1:0]       o_remainder,
  output logic               o_divide_by_zero,
  output logic               o_busy,
  output logic               o_div_start,
  output logic [N-1:0]       o_div_dividend,
  output logic [N-1:0]       o_div_divisor,
  input  logic               i_div_finished,
  input  logic [N-1:0]       i_div_quotient,
  input  logic [N-1:0]       i_div_remainder,
  input  logic               i_div_divide_by_zero,
  output logic [STATE_W-1:0] o_state
);

  // Handshake: a requester holds i_request[k] high until it sees o_done[k]
  // and drops it the following cycle; a request still high then is a new one.

  state_e          state_q;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] owner_q;
  logic [M-1:0]    grant_q;
  logic [M-1:0]    done_q;
  logic [ID_W-1:0] done_id_q;
  logic [N-1:0]    quot_q, rem_q;
  logic            dbz_q;
  logic            start_q;
  logic [N-1:0]    dvd_q, dvs_q;

  logic [M-1:0]    sel_grant;
  logic [ID_W-1:0] sel_idx;
  logic            sel_valid;

  rr_priority_select #(
    .M    (M),
    .ID_W (ID_W)
  ) u_sel (
    .req_i   (i_request),
    .ptr_i   (ptr_q),
    .grant_o (sel_grant),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  assign ptr_d = (owner_q == ID_W'(M - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      done_id_q <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
      start_q   <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      case (state_q)
        IDLE: begin
          if (sel_valid) begin
            grant_q <= sel_grant;
            owner_q <= sel_idx;
            dvd_q   <= i_dividend[sel_idx*N +: N];
            dvs_q   <= i_divisor[sel_idx*N +: N];
            start_q <= 1'b1;
            state_q <= LAUNCH;
          end
        end
        LAUNCH: state_q <= ARM;
        // A level-style finished flag may still be high from the last operation.
        ARM:    state_q <= WAIT;
        WAIT: begin
          if (i_div_finished) begin
            quot_q    <= i_div_quotient;
            rem_q     <= i_div_remainder;
            dbz_q     <= i_div_divide_by_zero;
            done_q    <= grant_q;
            done_id_q <= owner_q;
            state_q   <= DONE;
          end
        end
        DONE: begin
          grant_q <= '0;
          ptr_q   <= ptr_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_grant          = grant_q;
  assign o_done           = done_q;
  assign o_done_id        = done_id_q;
  assign o_quotient       = quot_q;
  assign o_remainder      = rem_q;
  assign o_divide_by_zero = dbz_q;
  assign o_busy           = (state_q != IDLE);
  assign o_div_start      = start_q;
  assign o_div_dividend   = dvd_q;
  assign o_div_divisor    = dvs_q;
  assign o_state          = state_q;

endmodule
